// File: rtl/daw_transport_sequencer.sv
// daw_transport_sequencer
// Transport (stop/play/pause) and step sequencer for the DAW main screen.
// Owns the tempo counter, the wrapping playhead and the tracks x steps
// pattern memory, and emits one-cycle step ticks and note columns.
// Optional feature macro: DAW_LOOP_LEN_EN adds a loop_end input that sets
// the last step before the playhead wraps back to 0.

module daw_transport_sequencer #(
    parameter int TRACKS     = 4,
    parameter int STEPS      = 16,
    parameter int TRK_W      = 2,
    parameter int STEP_W     = 4,
    parameter int PER_W      = 24,
    parameter int MIN_PERIOD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play_req,
    input  logic              pause_req,
    input  logic              stop_req,
    input  logic [PER_W-1:0]  tempo_period,
    input  logic              edit_we,
    input  logic [TRK_W-1:0]  edit_track,
    input  logic [STEP_W-1:0] edit_step,
    input  logic              clear_all,
    input  logic [TRK_W-1:0]  rd_track,
    input  logic [STEP_W-1:0] rd_step,
`ifdef DAW_LOOP_LEN_EN
    input  logic [STEP_W-1:0] loop_end,
`endif
    output logic              rd_cell,
    output logic [STEP_W-1:0] playhead,
    output logic              playing,
    output logic              paused,
    output logic              step_tick,
    output logic [TRACKS-1:0] note_on
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t            state;
    logic [PER_W-1:0]  counter;
    logic [STEPS-1:0]  pattern [TRACKS];

    logic [PER_W-1:0]  eff_period;
    logic [PER_W-1:0]  eff_last;
    logic              period_done;
    logic [STEP_W-1:0] next_step;
    logic [TRACKS-1:0] next_col;
    logic [TRACKS-1:0] first_col;

    // Tempo is clamped to the minimum period; a >= compare means a period
    // that shrinks below the running count ticks on the very next clock.
    assign eff_period  = (tempo_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : tempo_period;
    assign eff_last    = eff_period - PER_W'(1);
    assign period_done = (counter >= eff_last);

    // Next playhead position, wrapping at the loop end or at the last step.
`ifdef DAW_LOOP_LEN_EN
    assign next_step = (playhead >= loop_end) ? '0 : playhead + STEP_W'(1);
`else
    assign next_step = playhead + STEP_W'(1);
`endif

    // Note columns are read from the current (pre-edit) pattern contents.
    always_comb begin
        next_col  = '0;
        first_col = '0;
        for (int t = 0; t < TRACKS; t++) begin
            next_col[t]  = pattern[t][next_step];
            first_col[t] = pattern[t][0];
        end
    end

    // Transport state machine with registered status, tick and note outputs;
    // request priority is stop over pause over play in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_STOP;
            counter   <= '0;
            playhead  <= '0;
            playing   <= 1'b0;
            paused    <= 1'b0;
            step_tick <= 1'b0;
            note_on   <= '0;
        end else begin
            step_tick <= 1'b0;
            note_on   <= '0;
            case (state)
                ST_STOP: begin
                    if (!stop_req && !pause_req && play_req) begin
                        state     <= ST_PLAY;
                        playing   <= 1'b1;
                        paused    <= 1'b0;
                        counter   <= '0;
                        playhead  <= '0;
                        step_tick <= 1'b1;
                        note_on   <= first_col;
                    end
                end
                ST_PLAY: begin
                    if (stop_req) begin
                        state    <= ST_STOP;
                        playing  <= 1'b0;
                        paused   <= 1'b0;
                        counter  <= '0;
                        playhead <= '0;
                    end else if (pause_req) begin
                        state   <= ST_PAUSE;
                        playing <= 1'b0;
                        paused  <= 1'b1;
                    end else if (period_done) begin
                        counter   <= '0;
                        playhead  <= next_step;
                        step_tick <= 1'b1;
                        note_on   <= next_col;
                    end else begin
                        counter <= counter + PER_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop_req) begin
                        state    <= ST_STOP;
                        playing  <= 1'b0;
                        paused   <= 1'b0;
                        counter  <= '0;
                        playhead <= '0;
                    end else if (!pause_req && play_req) begin
                        state   <= ST_PLAY;
                        playing <= 1'b1;
                        paused  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_STOP;
                    playing  <= 1'b0;
                    paused   <= 1'b0;
                    counter  <= '0;
                    playhead <= '0;
                end
            endcase
        end
    end

    // Pattern memory: clear_all wins over a single-cell toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TRACKS; t++) begin
                pattern[t] <= '0;
            end
        end else if (clear_all) begin
            for (int t = 0; t < TRACKS; t++) begin
                pattern[t] <= '0;
            end
        end else if (edit_we) begin
            pattern[edit_track][edit_step] <= ~pattern[edit_track][edit_step];
        end
    end

    // Renderer read port, registered, returning the value before any same-cycle edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cell <= 1'b0;
        end else begin
            rd_cell <= pattern[rd_track][rd_step];
        end
    end

endmodule

// File: doc/daw_transport_sequencer.md
Name: daw_transport_sequencer

Overview:
- Transport and step-sequencer controller for the DAW main screen. Owns play/pause/stop state, the tempo counter, the wrapping playhead and the pattern memory (tracks x steps).
- Arbitrates pattern access between the UI edit port and the VGA renderer read port.
- Emits per-step note triggers for downstream audio/LED logic.
- Runs in the VGA pixel clock domain alongside daw_main_screen.

Parameters:
- TRACKS, 4, number of pattern rows (instruments)
- STEPS, 16, steps per pattern (power of 2)
- TRK_W, 2, log2(TRACKS)
- STEP_W, 4, log2(STEPS)
- PER_W, 24, tempo period counter width
- MIN_PERIOD, 16, minimum enforced step period in clocks

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- play_req  in  1  single-cycle pulse, start/resume
- pause_req  in  1  single-cycle pulse, pause
- stop_req  in  1  single-cycle pulse, stop and rewind
- tempo_period  in  PER_W  clocks per step
- edit_we  in  1  toggle one pattern cell this cycle
- edit_track  in  TRK_W  row to toggle
- edit_step  in  STEP_W  column to toggle
- clear_all  in  1  clear entire pattern
- rd_track  in  TRK_W  renderer read row
- rd_step  in  STEP_W  renderer read column
- rd_cell  out  1  registered cell value
- playhead  out  STEP_W  current step
- playing  out  1  state==PLAY
- paused  out  1  state==PAUSE
- step_tick  out  1  one-cycle pulse on each step advance
- note_on  out  TRACKS  one-cycle pulse, column of new playhead

Behaviour:
- Reset (async, rst_n=0):
  - state=STOP, playhead=0, counter=0.
  - step_tick=0, note_on=0, rd_cell=0, playing=0, paused=0.
  - Pattern cleared to 0.
- States:
  - STOP (0), PLAY (1), PAUSE (2). Encoding 3 is illegal and recovers to STOP.
- Request priority when pulses coincide: stop_req > pause_req > play_req.
- STOP:
  - play_req -> PLAY. On the same edge: playhead=0, counter=0, step_tick=1, note_on=pattern column 0.
  - pause_req is ignored.
- PLAY:
  - counter increments each clock.
  - When counter >= eff_period-1: counter=0, playhead=playhead+1 (wraps STEPS-1 -> 0), step_tick=1, note_on=column at the new playhead.
  - pause_req -> PAUSE (counter and playhead frozen).
  - stop_req -> STOP (playhead=0, counter=0, no tick).
  - play_req is ignored.
- PAUSE:
  - play_req -> PLAY with counter resumed from its frozen value and no immediate tick.
  - stop_req -> STOP.
- eff_period = max(tempo_period, MIN_PERIOD).
  - tempo_period is sampled live.
  - If the period drops below the current count, a tick occurs on the next clock (>= compare, never a full wrap of the counter).
- step_tick and note_on are high for exactly one cycle and are never asserted outside PLAY.
- Edit port:
  - edit_we toggles cell[edit_track][edit_step] at the clock edge.
  - clear_all overrides edit_we in the same cycle.
  - Edits are permitted in every state.
- Read port:
  - rd_cell = cell[rd_track][rd_step] registered, 1-cycle latency.
  - A read and an edit of the same cell in the same cycle returns the pre-edit value.
- Note-column snoop: if an edit targets the column being loaded into note_on in the same cycle, note_on uses the pre-edit value.
- Reset mid-PLAY aborts immediately; no residual tick after rst_n deasserts.

Optional Feature:
- Macro: DAW_LOOP_LEN_EN.
- Defined: adds input loop_end [STEP_W-1:0]. The playhead wraps to 0 after reaching loop_end. If playhead > loop_end when loop_end changes, the next advance wraps to 0.
- Undefined: no port; wrap at STEPS-1.

Test Plan:
- Reset, tempo_period=20, play_req at cycle 5 -> step_tick at cycle 5 with playhead=0, then ticks every 20 cycles; playhead sequence 1,2,…,15,0; 17th tick shows playhead=0.
- Toggle cells (track1, step0) and (track3, step2), play with period=16 -> note_on=4'b0010 on tick for step 0, 4'b1000 on tick for step 2, 0 elsewhere.
- PLAY with period 32; pause_req at count 10, hold 100 cycles, then play_req -> no ticks while paused; next tick 22 cycles after resume.
- stop_req, pause_req and play_req in the same cycle while PLAY -> STOP, playhead=0, no step_tick.
- tempo_period=5 -> effective period 16. Change 100 -> 10 while counter=50 -> tick on the next cycle.
- Edit and read of (2,7) in the same cycle from 0 -> rd_cell=0 next cycle; a re-read gives 1. clear_all -> all reads 0.
